// File: rtl/display_scan_ctrl.sv
// Purpose: time-multiplexed scan of NUM_DIGITS 7-segment digits with dead time and PWM brightness.
// Latency: all outputs registered; enable seen at cycle t starts a frame (frame_start) at t+1.
// Backpressure: one-deep pending buffer; upd_ready drops after a transfer and returns once the
//               pending value is moved into the displayed (shadow) set at a frame boundary or in IDLE.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 2,
  parameter int DWELL      = 1024,
  parameter int BLANK      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [3:0]                brightness,
  output logic [3:0]                seg_val,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_start
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  // One spare bit so the PWM threshold can reach DWELL itself (full brightness).
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int STEP = DWELL / 16;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic [IW-1:0]             idx_nxt;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_inc;
  logic [CW-1:0]             thr;
  logic [3:0]                b_lat;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic [4*NUM_DIGITS-1:0]   pending;
  logic [4*NUM_DIGITS-1:0]   shadow_nxt;
  logic [NUM_DIGITS-1:0]     sel_onehot;
  logic                      slot_end;
  logic                      boundary;
  logic                      accept;
  logic                      consume;

  assign cnt_inc    = cnt + CW'(1);
  // ON window length in cycles: (b_lat+1) sixteenths of the slot.
  assign thr        = CW'({1'b0, b_lat} + 5'd1) * CW'(STEP);
  assign sel_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  assign slot_end   = (state == S_ON) && (cnt == DWELL_END);
  // Frame boundary: last ON cycle of the last digit while still scanning.
  assign boundary   = enable && slot_end && (idx == LAST_IDX);
  assign accept     = upd_valid && upd_ready;
  // Pending data is only released into the display at a frame edge, or straight away when idle.
  assign consume    = !upd_ready && (boundary || (state == S_IDLE));
  assign shadow_nxt = consume ? pending : shadow;

  // Next digit index: cleared when disabled, advanced (with wrap) at the end of each ON slot.
  always_comb begin
    idx_nxt = idx;
    if (!enable) begin
      idx_nxt = '0;
    end else if (slot_end) begin
      idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end
  end

  // Update path: pending buffer, displayed shadow copy, and the value sent to the decoder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      shadow    <= '0;
      upd_ready <= 1'b1;
      seg_val   <= 4'h0;
    end else begin
      shadow  <= shadow_nxt;
      seg_val <= shadow_nxt[{idx_nxt, 2'b00} +: 4];
      if (accept) begin
        pending   <= digits_in;
        upd_ready <= 1'b0;
      end else if (consume) begin
        upd_ready <= 1'b1;
      end
    end
  end

  // Scan FSM: IDLE -> BLANK -> ON -> BLANK ..., with registered digit enables and frame pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      b_lat       <= 4'h0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      idx         <= idx_nxt;
      frame_start <= 1'b0;
      if (!enable) begin
        state    <= S_IDLE;
        cnt      <= '0;
        digit_en <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state       <= S_BLANK;
            cnt         <= '0;
            digit_en    <= '0;
            frame_start <= 1'b1;
          end
          S_BLANK: begin
            if (cnt == BLANK_END) begin
              // First ON cycle is always lit: the threshold is at least DWELL/16.
              state    <= S_ON;
              cnt      <= '0;
              b_lat    <= brightness;
              digit_en <= sel_onehot;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_ON: begin
            if (cnt == DWELL_END) begin
              state       <= S_BLANK;
              cnt         <= '0;
              digit_en    <= '0;
              frame_start <= (idx == LAST_IDX);
            end else begin
              cnt      <= cnt_inc;
              digit_en <= (cnt_inc < thr) ? sel_onehot : '0;
            end
          end
          default: begin
            state    <= S_IDLE;
            cnt      <= '0;
            digit_en <= '0;
          end
        endcase
      end
    end
  end

endmodule
